// File: rtl/screen_pixel_sequencer_if.sv
// Screen-draw bus: start/hold control, screen ROM address/data, and the
// x/y/colour/plot stream toward the VGA adapter.
interface screen_pixel_sequencer_if #(
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 3
);
    logic               start;
    logic               hold;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic [7:0]         x;
    logic [6:0]         y;
    logic [COLOR_W-1:0] colour;
    logic               plot;
    logic               busy;
    logic               done;

    modport master (
        input  start, hold, rom_data,
        output rom_addr, x, y, colour, plot, busy, done
    );

    modport slave (
        output start, hold, rom_data,
        input  rom_addr, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/screen_pixel_sequencer.sv
// Full-screen image sequencer: walks the screen ROM linearly and re-aligns
// the returned colour with its x/y coordinate to produce one plot per pixel.
module screen_pixel_sequencer #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 3,
    parameter int ROM_LAT = 1
) (
    input logic                      clk,
    input logic                      resetn,
    screen_pixel_sequencer_if.master bus
);
    localparam int                NPIX      = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [7:0]        LAST_X    = 8'(WIDTH - 1);
    localparam logic [6:0]        LAST_Y    = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ic;
    logic [7:0]          cx;
    logic [6:0]          cy;
    logic                busy;
    logic                done;

    // bit i of vld_p is pipeline stage i; the last stage lines up with rom_data
    logic [ROM_LAT-1:0]  vld_p;
    logic [7:0]          cx_p [ROM_LAT];
    logic [6:0]          cy_p [ROM_LAT];

    logic                plot;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOR_W-1:0]  colour;

    logic                issue;
    logic                pipe_empty;

    assign issue      = (state == FETCH) && !bus.hold;
    assign pipe_empty = (vld_p == '0);

    // Issue stage: FSM, address counters and the valid shift register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            ic    <= '0;
            cx    <= '0;
            cy    <= '0;
            vld_p <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            vld_p <= (vld_p << 1) | ROM_LAT'(issue);
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                        ic    <= '0;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                FETCH: begin
                    if (!bus.hold) begin
                        if (ic == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            ic <= ic + 1'b1;
                            if (cx == LAST_X) begin
                                cx <= '0;
                                if (cy != LAST_Y) cy <= cy + 1'b1;
                            end else begin
                                cx <= cx + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ic    <= '0;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Coordinate delay stages: pure data, shifted every cycle like vld_p
    always_ff @(posedge clk) begin
        cx_p[0] <= cx;
        cy_p[0] <= cy;
        for (int i = 1; i < ROM_LAT; i++) begin
            cx_p[i] <= cx_p[i-1];
            cy_p[i] <= cy_p[i-1];
        end
    end

    // Output stage: capture on a valid slot, otherwise hold the last pixel
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            plot <= vld_p[ROM_LAT-1];
            if (vld_p[ROM_LAT-1]) begin
                x      <= cx_p[ROM_LAT-1];
                y      <= cy_p[ROM_LAT-1];
                colour <= bus.rom_data;
            end
        end
    end

    assign bus.rom_addr = ic;
    assign bus.x        = x;
    assign bus.y        = y;
    assign bus.colour   = colour;
    assign bus.plot     = plot;
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule

// File: tb/tb_screen_pixel_sequencer.sv
// Directed bench: two sequencers (ROM latency 1 and 3) fed by behavioural
// ROMs; a negedge monitor scoreboards every plotted pixel in raster order.
`define CHK(tag, obs, exp) \
    begin \
        n_cmp++; \
        assert (int'(obs) === int'(exp)) else begin \
            n_bad++; \
            $error("FAIL %s: observed %0d expected %0d", tag, int'(obs), int'(exp)); \
        end \
    end

module tb_screen_pixel_sequencer;
    localparam int NPIX = 160 * 120;

    logic clk = 1'b0;
    logic resetn;
    always #10 clk = ~clk;

    screen_pixel_sequencer_if #(.ADDR_W(15), .COLOR_W(3)) b0 ();
    screen_pixel_sequencer_if #(.ADDR_W(15), .COLOR_W(3)) b1 ();

    screen_pixel_sequencer #(.WIDTH(160), .HEIGHT(120), .ADDR_W(15), .COLOR_W(3), .ROM_LAT(1))
        dut0 (.clk(clk), .resetn(resetn), .bus(b0));
    screen_pixel_sequencer #(.WIDTH(160), .HEIGHT(120), .ADDR_W(15), .COLOR_W(3), .ROM_LAT(3))
        dut1 (.clk(clk), .resetn(resetn), .bus(b1));

    function automatic logic [2:0] rom_word(input int a);
        return 3'((a ^ (a >> 3)) + (a >> 7));
    endfunction

    // behavioural screen ROMs
    logic [2:0] rom1_q;
    logic [2:0] rom3_q0, rom3_q1, rom3_q2;
    always @(posedge clk) begin
        rom1_q  <= rom_word(int'(b0.rom_addr));
        rom3_q0 <= rom_word(int'(b1.rom_addr));
        rom3_q1 <= rom3_q0;
        rom3_q2 <= rom3_q1;
    end
    assign b0.rom_data = rom1_q;
    assign b1.rom_data = rom3_q2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int run_id = 0;
    int seen_run = 0;

    int nplots [2];
    int px_bad [2];
    int first_cyc [2];
    int last_cyc [2];
    int done_cnt [2];
    int done_cyc [2];
    int outside [2];

    task automatic mon(input int d, input logic p, input logic bz, input logic dn,
                       input logic [7:0] xx, input logic [6:0] yy, input logic [2:0] cc);
        int idx;
        if (p === 1'b1) begin
            idx = nplots[d];
            if (int'(xx) != idx % 160 || int'(yy) != idx / 160 || cc !== rom_word(idx))
                px_bad[d]++;
            if (bz !== 1'b1) outside[d]++;
            if (nplots[d] == 0) first_cyc[d] = cyc;
            last_cyc[d] = cyc;
            nplots[d]++;
        end
        if (dn === 1'b1) begin
            done_cnt[d]++;
            done_cyc[d] = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (run_id != seen_run) begin
            seen_run = run_id;
            for (int d = 0; d < 2; d++) begin
                nplots[d] = 0; px_bad[d] = 0; first_cyc[d] = 0; last_cyc[d] = 0;
                done_cnt[d] = 0; done_cyc[d] = 0; outside[d] = 0;
            end
        end
        mon(0, b0.plot, b0.busy, b0.done, b0.x, b0.y, b0.colour);
        mon(1, b1.plot, b1.busy, b1.done, b1.x, b1.y, b1.colour);
    end

    task automatic wait_done(input int d);
        int k = 0;
        while (done_cnt[d] == 0 && k < 25000) begin
            @(negedge clk);
            k++;
        end
        `CHK("done_seen", done_cnt[d] != 0, 1)
    endtask

    int e0;
    int k;

    initial begin
        resetn = 1'b0;
        b0.start = 1'b0; b0.hold = 1'b0;
        b1.start = 1'b0; b1.hold = 1'b0;
        repeat (3) @(negedge clk);
        `CHK("rst_plot", b0.plot, 0)
        `CHK("rst_busy", b0.busy, 0)
        `CHK("rst_done", b0.done, 0)
        `CHK("rst_addr", b0.rom_addr, 0)
        `CHK("rst_x", b0.x, 0)
        `CHK("rst_colour", b0.colour, 0)
        resetn = 1'b1;
        @(negedge clk);
        `CHK("idle_addr", b0.rom_addr, 0)
        `CHK("idle_plot", b0.plot, 0)

        // Run 1: both latencies, no hold
        run_id++;
        b0.start = 1'b1; b1.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0; b1.start = 1'b0;
        e0 = cyc;
        `CHK("busy0_on", b0.busy, 1)
        `CHK("busy1_on", b1.busy, 1)
        k = 0;
        while (b0.rom_addr !== 15'd159 && k < 1000) begin @(negedge clk); k++; end
        `CHK("wrap_addr159", b0.rom_addr, 159)
        @(negedge clk);
        `CHK("wrap_addr160", b0.rom_addr, 160)
        wait_done(0);
        wait_done(1);
        repeat (2) @(negedge clk);
        `CHK("r1_plots", nplots[0], NPIX)
        `CHK("r1_pixels", px_bad[0], 0)
        `CHK("r1_first", first_cyc[0], e0 + 2)
        `CHK("r1_last", last_cyc[0], e0 + NPIX + 1)
        `CHK("r1_done_at", done_cyc[0], e0 + NPIX + 2)
        `CHK("r1_done_len", done_cnt[0], 1)
        `CHK("r1_busy_off", b0.busy, 0)
        `CHK("r1_outside", outside[0], 0)
        `CHK("l3_plots", nplots[1], NPIX)
        `CHK("l3_pixels", px_bad[1], 0)
        `CHK("l3_first", first_cyc[1], e0 + 4)
        `CHK("l3_last", last_cyc[1], e0 + NPIX + 3)
        `CHK("l3_done_at", done_cyc[1], e0 + NPIX + 4)
        `CHK("l3_done_len", done_cnt[1], 1)
        `CHK("l3_busy_off", b1.busy, 0)

        // Run 2: 5-cycle hold at address 300, stray start at pixel 1000
        run_id++;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        e0 = cyc;
        k = 0;
        while (b0.rom_addr !== 15'd300 && k < 1000) begin @(negedge clk); k++; end
        `CHK("hold_reach", b0.rom_addr, 300)
        b0.hold = 1'b1;
        repeat (5) @(negedge clk);
        `CHK("hold_frozen", b0.rom_addr, 300)
        b0.hold = 1'b0;
        k = 0;
        while (nplots[0] < 1000 && k < 2000) begin @(negedge clk); k++; end
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        `CHK("restart_busy", b0.busy, 1)
        wait_done(0);
        repeat (3) @(negedge clk);
        `CHK("r2_plots", nplots[0], NPIX)
        `CHK("r2_pixels", px_bad[0], 0)
        `CHK("r2_bubbles", last_cyc[0] - first_cyc[0] + 1 - nplots[0], 5)
        `CHK("r2_done_at", done_cyc[0], e0 + NPIX + 7)
        `CHK("r2_done_len", done_cnt[0], 1)

        // Run 3: reset mid-draw, then a fresh draw
        run_id++;
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        k = 0;
        while (nplots[0] < 5000 && k < 6000) begin @(negedge clk); k++; end
        #2 resetn = 1'b0;
        #1;
        `CHK("abort_plot", b0.plot, 0)
        `CHK("abort_busy", b0.busy, 0)
        `CHK("abort_done", b0.done, 0)
        `CHK("abort_addr", b0.rom_addr, 0)
        @(negedge clk);
        resetn = 1'b1;
        run_id++;
        repeat (4) @(negedge clk);
        `CHK("post_rst_plots", nplots[0], 0)
        `CHK("post_rst_busy", b0.busy, 0)
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        e0 = cyc;
        wait_done(0);
        repeat (2) @(negedge clk);
        `CHK("r3_plots", nplots[0], NPIX)
        `CHK("r3_pixels", px_bad[0], 0)
        `CHK("r3_first", first_cyc[0], e0 + 2)
        `CHK("r3_done_at", done_cyc[0], e0 + NPIX + 2)

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
